twiddle_cos_rom_server: RTL and testbench

//  Responder side of the quarter-wave twiddle ROM interface (twact/twa -> twdr_cos) used by the FFT twiddle bridge.

---
 rtl/twiddle_cos_rom_server_pkg.sv | 19 +
 rtl/twiddle_cos_rom_server_if.sv | 23 ++
 rtl/twiddle_cos_rom_server_ram.sv | 26 ++
 rtl/twiddle_cos_rom_server.sv | 94 +++++++++
 tb/tb_twiddle_cos_rom_server.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/twiddle_cos_rom_server_pkg.sv
// Shared types and sizing helpers for the quarter-wave cosine twiddle table server.
package fft_twiddle_pkg;

  typedef enum logic {
    LOAD  = 1'b0,
    SERVE = 1'b1
  } tw_state_e;

  localparam int unsigned CHECKSUM_W = 16;

  function automatic int unsigned tw_depth(input int unsigned fft_n);
    return 32'd1 << (fft_n - 32'd2);
  endfunction

  function automatic int unsigned tw_aw(input int unsigned fft_n);
    return fft_n - 32'd2;
  endfunction

endpackage

// File: rtl/twiddle_cos_rom_server_if.sv
// Read bus (twact/twa/twdr_cos) and table load stream between the bridge/loader and the server.
interface twiddle_cos_rom_server_if #(
  parameter int unsigned FFT_N  = 10,
  parameter int unsigned FFT_DW = 16
);
  logic                twact;
  logic [FFT_N-3:0]    twa;
  logic [FFT_DW-2:0]   twdr_cos;
  logic                ld_valid;
  logic                ld_ready;
  logic [FFT_DW-2:0]   ld_data;
  logic                reload;

  modport master (
    output twact, twa, ld_valid, ld_data, reload,
    input  twdr_cos, ld_ready
  );

  modport slave (
    input  twact, twa, ld_valid, ld_data, reload,
    output twdr_cos, ld_ready
  );
endinterface

// File: rtl/twiddle_cos_rom_server_ram.sv
// Simple dual-port table RAM: one write port, one registered read port, no array reset.
module twiddle_cos_ram #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = 8,
  parameter int unsigned DW    = 15
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/twiddle_cos_rom_server.sv
// Quarter-wave cosine twiddle server: streamed table load, 1-cycle registered reads,
// load progress/checksum reporting and sticky integrity flags.
module twiddle_cos_rom_server
  import fft_twiddle_pkg::*;
#(
  parameter int unsigned FFT_N  = 10,
  parameter int unsigned FFT_DW = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  twiddle_cos_rom_server_if.slave bus,
  output logic                   tw_ready,
  output logic [FFT_N-2:0]       ld_count,
  output logic [CHECKSUM_W-1:0]  checksum,
  output logic                   err_early_read,
  output logic                   err_monotonic
);

  localparam int unsigned DEPTH = tw_depth(FFT_N);
  localparam int unsigned AW    = tw_aw(FFT_N);
  localparam int unsigned DW    = FFT_DW - 1;
  localparam int unsigned CW    = FFT_N - 1;

  tw_state_e             state_q, state_d;
  logic [CW-1:0]         ld_count_q;
  logic [CHECKSUM_W-1:0] checksum_q;
  logic [DW-1:0]         prev_q;
  logic                  zero_q;
  logic                  err_early_q, err_mono_q;
  logic                  xfer, last_xfer, serving, rd_en;
  logic [DW-1:0]         ram_rdata;

  assign serving   = (state_q == SERVE);
  assign xfer      = bus.ld_valid && bus.ld_ready && !bus.reload;
  assign last_xfer = xfer && (ld_count_q == CW'(DEPTH - 1));
  assign rd_en     = bus.twact && serving;

  always_comb begin
    state_d = state_q;
    if (bus.reload)    state_d = LOAD;
    else if (last_xfer) state_d = SERVE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= LOAD;
      ld_count_q  <= '0;
      checksum_q  <= '0;
      prev_q      <= '0;
      zero_q      <= 1'b1;
      err_early_q <= 1'b0;
      err_mono_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (bus.reload) begin
        ld_count_q <= '0;
        checksum_q <= '0;
      end else if (xfer) begin
        ld_count_q <= ld_count_q + CW'(1);
        checksum_q <= checksum_q + CHECKSUM_W'(bus.ld_data);
        prev_q     <= bus.ld_data;
        if (ld_count_q != '0 && bus.ld_data > prev_q) err_mono_q <= 1'b1;
      end
      // The RAM port holds its last data; zero_q masks it after early reads so twdr_cos holds too.
      if (bus.twact) begin
        zero_q <= !serving;
        if (!serving) err_early_q <= 1'b1;
      end
    end
  end

  twiddle_cos_ram #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_ram (
    .clk   (clk),
    .we    (xfer),
    .waddr (ld_count_q[AW-1:0]),
    .wdata (bus.ld_data),
    .re    (rd_en),
    .raddr (bus.twa),
    .rdata (ram_rdata)
  );

  assign bus.ld_ready   = (state_q == LOAD);
  assign bus.twdr_cos   = zero_q ? '0 : ram_rdata;
  assign tw_ready       = serving;
  assign ld_count       = ld_count_q;
  assign checksum       = checksum_q;
  assign err_early_read = err_early_q;
  assign err_monotonic  = err_mono_q;

endmodule

// File: tb/tb_twiddle_cos_rom_server.sv
// Randomized bench for twiddle_cos_rom_server against a queue-style table model.
module tb_twiddle_cos_rom_server;

  localparam int unsigned FFT_N  = 5;
  localparam int unsigned FFT_DW = 16;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        tw_ready;
  logic [3:0]  ld_count;
  logic [15:0] checksum;
  logic        err_early_read, err_monotonic;

  twiddle_cos_rom_server_if #(.FFT_N(FFT_N), .FFT_DW(FFT_DW)) bus ();

  twiddle_cos_rom_server #(.FFT_N(FFT_N), .FFT_DW(FFT_DW)) dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus),
    .tw_ready       (tw_ready),
    .ld_count       (ld_count),
    .checksum       (checksum),
    .err_early_read (err_early_read),
    .err_monotonic  (err_monotonic)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  int golden [DEPTH] = '{32767, 32138, 30273, 27245, 23170, 18204, 12539, 6393};

  // Model: the current load is the list of accepted words; serving means the list is full.
  int m_tab [DEPTH];
  int m_cnt, m_twd;
  bit m_err_early, m_err_mono;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int model_sum();
    int s = 0;
    for (int i = 0; i < m_cnt; i++) s += m_tab[i];
    return s % 65536;
  endfunction

  task automatic check_all();
    check("ld_count", int'(ld_count), m_cnt);
    check("checksum", int'(checksum), model_sum());
    check("tw_ready", int'(tw_ready), int'(m_cnt == DEPTH));
    check("ld_ready", int'(bus.ld_ready), int'(m_cnt < DEPTH));
    check("twdr_cos", int'(bus.twdr_cos), m_twd);
    check("err_early_read", int'(err_early_read), int'(m_err_early));
    check("err_monotonic", int'(err_monotonic), int'(m_err_mono));
  endtask

  task automatic cycle(input bit v, input int d, input bit rl, input bit ta, input int a);
    bus.ld_valid = v;
    bus.ld_data  = 15'(d);
    bus.reload   = rl;
    bus.twact    = ta;
    bus.twa      = 3'(a);
    @(posedge clk);
    if (ta) begin
      if (m_cnt == DEPTH) m_twd = m_tab[a % DEPTH];
      else begin
        m_twd = 0;
        m_err_early = 1'b1;
      end
    end
    if (rl) m_cnt = 0;
    else if (v && m_cnt < DEPTH) begin
      if (m_cnt > 0 && d > m_tab[m_cnt-1]) m_err_mono = 1'b1;
      m_tab[m_cnt] = d;
      m_cnt++;
    end
    #1;
    check_all();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.ld_valid = 1'b0;
    bus.reload   = 1'b0;
    bus.twact    = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_cnt = 0;
    m_twd = 0;
    m_err_early = 1'b0;
    m_err_mono  = 1'b0;
    check_all();
  endtask

  // Streams a table with random valid gaps; bounded so a stuck ld_ready cannot hang the run.
  task automatic load_table(input int tab [DEPTH], input bit gapped);
    int guard = 0;
    while (m_cnt < DEPTH && guard < 200) begin
      if (gapped && $urandom_range(0, 2) == 0) cycle(1'b0, 0, 1'b0, 1'b0, 0);
      else cycle(1'b1, tab[m_cnt], 1'b0, 1'b0, 0);
      guard++;
    end
  endtask

  task automatic random_reads(input int n);
    for (int i = 0; i < n; i++)
      cycle(1'b0, 0, 1'b0, 1'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH - 1)));
  endtask

  initial begin
    int golden_sum = 0;
    int tab4 [DEPTH];
    int rnd [DEPTH];
    for (int i = 0; i < DEPTH; i++) golden_sum += golden[i];
    golden_sum = golden_sum % 65536;
    bus.ld_data = '0;
    bus.twa     = '0;

    // 1: nominal load with ld_valid held high
    do_reset();
    load_table(golden, 1'b0);
    check("t1_checksum_abs", int'(checksum), golden_sum);
    check("t1_count_abs", int'(ld_count), DEPTH);

    // 2: back-to-back reads, then hold
    cycle(1'b0, 0, 1'b0, 1'b1, 2);
    check("t2_rd2", int'(bus.twdr_cos), 30273);
    cycle(1'b0, 0, 1'b0, 1'b1, 6);
    check("t2_rd6", int'(bus.twdr_cos), 12539);
    cycle(1'b0, 0, 1'b0, 1'b0, 0);
    cycle(1'b0, 0, 1'b0, 1'b0, 3);
    check("t2_hold", int'(bus.twdr_cos), 12539);
    random_reads(20);

    // 3: early read before load completes
    do_reset();
    cycle(1'b1, golden[0], 1'b0, 1'b1, 0);
    check("t3_early_zero", int'(bus.twdr_cos), 0);
    check("t3_early_flag", int'(err_early_read), 1);
    load_table(golden, 1'b1);
    cycle(1'b0, 0, 1'b0, 1'b1, 0);
    check("t3_rd0_full_scale", int'(bus.twdr_cos), 32767);
    check("t3_flag_sticky", int'(err_early_read), 1);

    // 4: non-monotonic word 3
    do_reset();
    tab4 = golden;
    tab4[3] = 31000;
    load_table(tab4, 1'b1);
    check("t4_mono_flag", int'(err_monotonic), 1);
    cycle(1'b0, 0, 1'b0, 1'b1, 3);
    check("t4_rd3", int'(bus.twdr_cos), 31000);

    // 5: reload concurrent with ld_valid in SERVE; err flags survive reload
    cycle(1'b1, 1234, 1'b1, 1'b0, 0);
    check("t5_count0", int'(ld_count), 0);
    check("t5_not_ready", int'(tw_ready), 0);
    check("t5_mono_kept", int'(err_monotonic), 1);
    for (int i = 0; i < DEPTH; i++) rnd[i] = int'($urandom_range(0, 32767));
    load_table(rnd, 1'b1);
    random_reads(24);

    // 6: reset mid-load with gapped valid, then full reload
    do_reset();
    begin
      int guard = 0;
      while (m_cnt < 4 && guard < 100) begin
        cycle(1'($urandom_range(0, 1)), golden[m_cnt], 1'b0, 1'b0, 0);
        guard++;
      end
    end
    do_reset();
    check("t6_count0", int'(ld_count), 0);
    check("t6_sum0", int'(checksum), 0);
    check("t6_ld_ready", int'(bus.ld_ready), 1);
    load_table(golden, 1'b1);
    check("t6_checksum_abs", int'(checksum), golden_sum);
    random_reads(16);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
